// File: rtl/variable_shift_pkg.sv
// Shared encodings for the iterative variable shifter.
package variable_shift_pkg;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of 0..STEP bits in any of the four modes.
// With VARIABLE_SHIFT_STICKY_EN it also reports the OR of bits leaving the LSB.
module shift_step
    import variable_shift_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0]  work,
    input  logic [SHAMT_W-1:0] n,
    input  mode_e              mode,
`ifdef VARIABLE_SHIFT_STICKY_EN
    output logic               shifted_out,
`endif
    output logic [DATA_W-1:0]  next_work
);

    always_comb begin
        next_work = work;
        unique case (mode)
            MODE_SLL: next_work = work << n;
            MODE_SRL: next_work = work >> n;
            MODE_SRA: next_work = $signed(work) >>> n;
            // Doubling the operand turns the rotate into a plain right shift.
            MODE_ROR: next_work = DATA_W'({work, work} >> n);
            default:  next_work = work;
        endcase
    end

`ifdef VARIABLE_SHIFT_STICKY_EN
    assign shifted_out = |(work & ~({DATA_W{1'b1}} << n));
`endif

endmodule

// File: rtl/variable_shift_multi.sv
// Iterative variable shifter: up to STEP bits per cycle, registered result and done pulse.
// Optional sticky output (OR of bits shifted out on SRL/SRA) under VARIABLE_SHIFT_STICKY_EN.
module variable_shift_multi
    import variable_shift_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int STEP    = 1,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               data_start,
    input  logic [DATA_W-1:0]  a,
    input  logic [SHAMT_W-1:0] shift_width,
    input  logic [1:0]         mode,
    output logic               ready,
    output logic               busy,
    output logic               done,
`ifdef VARIABLE_SHIFT_STICKY_EN
    output logic               sticky,
`endif
    output logic [DATA_W-1:0]  shifted_a
);

    localparam logic [SHAMT_W-1:0] STEP_N = SHAMT_W'(STEP);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [DATA_W-1:0]  work_q, work_d, work_step;
    logic [DATA_W-1:0]  shifted_a_q, shifted_a_d;
    logic [SHAMT_W-1:0] remaining_q, remaining_d, n;

    // Never step past the requested amount, so remaining cannot underflow.
    assign n = (remaining_q < STEP_N) ? remaining_q : STEP_N;

`ifdef VARIABLE_SHIFT_STICKY_EN
    logic shout, acc_q, acc_d, sticky_q, sticky_d;
`endif

    shift_step #(
        .DATA_W (DATA_W),
        .SHAMT_W(SHAMT_W)
    ) u_shift_step (
        .work       (work_q),
        .n          (n),
        .mode       (mode_q),
`ifdef VARIABLE_SHIFT_STICKY_EN
        .shifted_out(shout),
`endif
        .next_work  (work_step)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        work_d      = work_q;
        remaining_d = remaining_q;
        shifted_a_d = shifted_a_q;
`ifdef VARIABLE_SHIFT_STICKY_EN
        acc_d       = acc_q;
        sticky_d    = sticky_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (data_start) begin
                    work_d      = a;
                    remaining_d = shift_width;
                    mode_d      = mode_e'(mode);
                    state_d     = ST_SHIFT;
`ifdef VARIABLE_SHIFT_STICKY_EN
                    acc_d       = 1'b0;
`endif
                end
            end
            ST_SHIFT: begin
                if (remaining_q == '0) begin
                    shifted_a_d = work_q;
                    state_d     = ST_DONE;
`ifdef VARIABLE_SHIFT_STICKY_EN
                    sticky_d    = acc_q;
`endif
                end else begin
                    work_d      = work_step;
                    remaining_d = remaining_q - n;
`ifdef VARIABLE_SHIFT_STICKY_EN
                    if (mode_q == MODE_SRL || mode_q == MODE_SRA) acc_d = acc_q | shout;
`endif
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_SLL;
            work_q      <= '0;
            remaining_q <= '0;
            shifted_a_q <= '0;
`ifdef VARIABLE_SHIFT_STICKY_EN
            acc_q       <= 1'b0;
            sticky_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            work_q      <= work_d;
            remaining_q <= remaining_d;
            shifted_a_q <= shifted_a_d;
`ifdef VARIABLE_SHIFT_STICKY_EN
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
`endif
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_SHIFT);
    assign done      = (state_q == ST_DONE);
    assign shifted_a = shifted_a_q;
`ifdef VARIABLE_SHIFT_STICKY_EN
    assign sticky    = sticky_q;
`endif

endmodule

// File: doc/variable_shift_multi.md
Name: variable_shift_multi

Overview:
- Parametrised iterative variable shifter; successor of the 1-bit-per-cycle shifter.
- Accepts one operand per start pulse and shifts by up to STEP bits per cycle until the requested amount is consumed.
- Supports four modes: logical left, logical right, arithmetic right and rotate right.
- Sits behind the counter/PLL data-start timing in the datapath; returns a registered result with a one-cycle done pulse.

Parameters:
DATA_W, 8, operand/result width; power of two, >= 4
STEP, 1, maximum bits shifted per cycle; 1..DATA_W-1
SHAMT_W, $clog2(DATA_W), shift-amount width (derived; do not override)

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST  input  1  asynchronous, active-high reset
data_start  input  1  start pulse; sampled only when ready=1
a  input  DATA_W  operand, captured on an accepted start
shift_width  input  SHAMT_W  shift amount 0..DATA_W-1, captured on start
mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR; captured on start
ready  output  1  high in IDLE only
busy  output  1  high in SHIFT
done  output  1  one-cycle pulse; result valid
shifted_a  output  DATA_W  result; holds its value until the next done

Behaviour:
- Reset (async, RST=1): state=IDLE, work=0, remaining=0, shifted_a=0, done=0, busy=0, ready=1.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - data_start=1 on an edge: latch a into work, shift_width into remaining, mode into mode_r; go to SHIFT.
  - data_start=0: hold.
- SHIFT:
  - If remaining==0: shifted_a<=work, done<=1, go to DONE.
  - Else: n=min(STEP,remaining); work shifted by n per mode_r; remaining-=n.
- DONE: done<=0 on the next edge; go to IDLE.
- Latency: start edge to done-high = ceil(shift_width/STEP)+1 cycles.
  - shift_width=0 gives 1 cycle and shifted_a=a.
  - Throughput: one operation per latency+2 cycles.
- Mode rules:
  - SLL: zero fill from LSB.
  - SRL: zero fill from MSB.
  - SRA: MSB of the latched operand replicated.
  - ROR: bits leaving the LSB re-enter at the MSB.
- Arithmetic: remaining is SHAMT_W wide and never underflows (n<=remaining). No width growth; result is always DATA_W.
- data_start while in SHIFT or DONE: ignored; no queuing, latched operands unchanged.
- Inputs a, shift_width and mode may change freely after acceptance.
- RST asserted mid-operation: immediate return to reset values; no done pulse for the aborted operation.
- ready, busy and done are decoded from registered state and are mutually exclusive.

Optional Feature:
- Macro: VARIABLE_SHIFT_STICKY_EN.
- Defined:
  - Extra output sticky (1 bit): OR of every bit shifted out of the LSB during SRL/SRA.
  - Cleared on accepted start; valid with done; held until the next done.
  - Forced 0 for SLL and ROR.
  - Reset value 0.
- Undefined: port absent; no sticky logic.

Decomposition:
- Shared package variable_shift_pkg holds:
  - mode encodings: MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROR
  - state encodings: ST_IDLE, ST_SHIFT, ST_DONE
- One combinational sub-module, shift_step:
  - Inputs: work, n (0..STEP), mode.
  - Outputs: next work and shifted-out OR (the latter used only under the macro).
- Top level holds the FSM, the remaining counter and the output registers.

Test Plan:
1. DATA_W=8, STEP=1; a=8'h96, shift_width=3, mode=SLL -> done 4 cycles after start; shifted_a=8'hB0.
2. STEP=1; a=8'h96, shift_width=3, mode=SRA -> shifted_a=8'hF2. Same with mode=SRL -> 8'h12. Same with mode=ROR -> 8'hD2.
3. STEP=3; a=8'h81, shift_width=7, mode=ROR -> steps 3,3,1; done 4 cycles after start; shifted_a=8'h03.
4. shift_width=0, a=8'h5A, any mode -> done 1 cycle after start; shifted_a=8'h5A.
5. Second data_start pulses during SHIFT and during DONE -> ignored; the result matches the first operand; ready returns high only after done.
6. RST pulsed 2 cycles into a 7-bit SLL -> shifted_a=0, ready=1 immediately, no done pulse. With VARIABLE_SHIFT_STICKY_EN, a=8'h05, shift_width=2, SRL -> shifted_a=8'h01, sticky=1.
